// File: rtl/ntt_stream_if.sv
// Handshake and BRAM-side bundle between the NTT batch controller and its environment.
// The slave modport is the controller's view; the master modport is the driving side.
interface ntt_stream_if #(
  parameter int LOGN   = 12,
  parameter int LOGP   = 2,
  parameter int ADDR_W = LOGN + LOGP
);
  logic              start;
  logic              intt;
  logic [LOGP:0]     num_poly;
  logic              bitrev_out;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              ntt_start;
  logic              ntt_intt;
  logic              ntt_in_valid;
  logic              ntt_out_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [LOGP:0]     poly_done;
  logic              error;

  modport slave (
    input  start, intt, num_poly, bitrev_out, ntt_out_valid,
    output busy, done, rd_en, rd_addr, ntt_start, ntt_intt, ntt_in_valid,
           wr_en, wr_addr, poly_done, error
  );

  modport master (
    output start, intt, num_poly, bitrev_out, ntt_out_valid,
    input  busy, done, rd_en, rd_addr, ntt_start, ntt_intt, ntt_in_valid,
           wr_en, wr_addr, poly_done, error
  );
endinterface

// File: rtl/ntt_stream_controller.sv
// Batch controller feeding up to 2^LOGP polynomials from coefficient BRAM into a streaming
// SDF NTT core and writing the core's output stream back to a result BRAM.
//
// state | meaning
// IDLE  | waiting for start; config latched on accepted start
// WAIT  | start delay countdown before the first read
// READ  | one BRAM read per cycle, T reads in total
// DRAIN | reads finished, collecting remaining core outputs
// DONE  | one-cycle done pulse, then back to IDLE
module ntt_stream_controller #(
  parameter int LOGN        = 12,
  parameter int LOGP        = 2,
  parameter int START_DELAY = 10,
  parameter int RD_LAT      = 2,
  parameter int ADDR_W      = LOGN + LOGP
) (
  input logic        clk,
  input logic        rst,
  ntt_stream_if.slave bus
);

  localparam int CW = ADDR_W + 1;
  localparam int DW = (START_DELAY > 2) ? $clog2(START_DELAY - 1) : 1;
  localparam logic [DW-1:0] DLY_LOAD = DW'((START_DELAY > 1) ? START_DELAY - 2 : 0);
  localparam logic [LOGP:0] NPOLY_MAX = {1'b1, {LOGP{1'b0}}};
  localparam logic [LOGP:0] NPOLY_ONE = {{LOGP{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, WAIT, READ, DRAIN, DONE} state_t;

  state_t          state, state_nx;
  logic [DW-1:0]   dcnt;
  logic [CW-1:0]   rd_cnt;
  logic [CW-1:0]   wr_cnt;
  logic            intt_q;
  logic            bitrev_q;
  logic [LOGP:0]   np_q;
  logic            error_q;

  logic            start_acc;
  logic [LOGP:0]   np_clamped;
  logic [CW-1:0]   t_val;
  logic [CW-1:0]   t_last;
  logic            wr_window;
  logic            rd_en;
  logic            wr_en;
  logic            err_set;
  logic            busy;
  logic            done;
  logic            ntt_start;
  logic            in_valid;

  function automatic logic [LOGN-1:0] bit_rev(input logic [LOGN-1:0] x);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = x[LOGN-1-i];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    start_acc  = 1'b0;
    rd_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    ntt_start  = 1'b0;
    wr_window  = 1'b0;
    wr_en      = 1'b0;
    err_set    = 1'b0;
    np_clamped = bus.num_poly;
    t_val      = {np_q, {LOGN{1'b0}}};
    t_last     = t_val - CW'(1);

    if (bus.num_poly == '0)            np_clamped = NPOLY_ONE;
    else if (bus.num_poly > NPOLY_MAX) np_clamped = NPOLY_MAX;

    unique case (state)
      WAIT:  busy = 1'b1;
      READ:  begin busy = 1'b1; rd_en = 1'b1; ntt_start = 1'b1; wr_window = 1'b1; end
      DRAIN: begin busy = 1'b1; ntt_start = 1'b1; wr_window = 1'b1; end
      DONE:  done = 1'b1;
      default: ;
    endcase

    // Writes stop once T samples are stored; any further valid is flagged, never written.
    wr_en   = bus.ntt_out_valid && wr_window && (wr_cnt < t_val);
    err_set = bus.ntt_out_valid && (!wr_window || (wr_cnt == t_val));

    unique case (state)
      IDLE: if (bus.start) begin
        start_acc = 1'b1;
        state_nx  = (START_DELAY > 1) ? WAIT : READ;
      end
      WAIT:  if (dcnt == '0) state_nx = READ;
      READ:  if (rd_cnt == t_last) state_nx = DRAIN;
      // Leave on the edge of the final write so done follows it by exactly one cycle.
      DRAIN: if ((wr_cnt == t_val) || (wr_en && (wr_cnt == t_last))) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt     <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      intt_q   <= 1'b0;
      bitrev_q <= 1'b0;
      np_q     <= '0;
      error_q  <= 1'b0;
    end else begin
      if (start_acc) begin
        dcnt     <= DLY_LOAD;
        rd_cnt   <= '0;
        wr_cnt   <= '0;
        intt_q   <= bus.intt;
        bitrev_q <= bus.bitrev_out;
        np_q     <= np_clamped;
      end else begin
        if ((state == WAIT) && (dcnt != '0)) dcnt <= dcnt - DW'(1);
        if (rd_en) rd_cnt <= rd_cnt + CW'(1);
        if (wr_en) wr_cnt <= wr_cnt + CW'(1);
      end
      error_q <= err_set || (error_q && !start_acc);
    end
  end

  generate
    if (RD_LAT == 0) begin : g_no_lat
      assign in_valid = rd_en;
    end else begin : g_lat
      logic [RD_LAT-1:0] dly;
      always_ff @(posedge clk) begin
        if (rst) dly <= '0;
        else     dly <= RD_LAT'({dly, rd_en});
      end
      assign in_valid = dly[RD_LAT-1];
    end
  endgenerate

  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.rd_en        = rd_en;
  assign bus.rd_addr      = rd_cnt[ADDR_W-1:0];
  assign bus.ntt_start    = ntt_start;
  assign bus.ntt_intt     = intt_q;
  assign bus.ntt_in_valid = in_valid;
  assign bus.wr_en        = wr_en;
  assign bus.wr_addr      = {wr_cnt[ADDR_W-1:LOGN],
                             bitrev_q ? bit_rev(wr_cnt[LOGN-1:0]) : wr_cnt[LOGN-1:0]};
  assign bus.poly_done    = wr_cnt[ADDR_W:LOGN];
  assign bus.error        = error_q;

endmodule

// File: tb/tb_ntt_stream_controller.sv
// Directed bench for ntt_stream_controller: N=8, up to 4 polynomials, start delay 4, read latency 2.
// Expected per-cycle values come from cycle-number formulas relative to the accepted start.
module tb_ntt_stream_controller;
  localparam int LOGN = 3;
  localparam int LOGP = 2;
  localparam int SD   = 4;
  localparam int RL   = 2;
  localparam int AW   = LOGN + LOGP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntt_stream_if #(.LOGN(LOGN), .LOGP(LOGP), .ADDR_W(AW)) bus();

  ntt_stream_controller #(
    .LOGN(LOGN), .LOGP(LOGP), .START_DELAY(SD), .RD_LAT(RL), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] rev3(input logic [2:0] x);
    return {x[0], x[1], x[2]};
  endfunction

  task automatic idle_inputs();
    bus.start         = 1'b0;
    bus.intt          = 1'b0;
    bus.num_poly      = '0;
    bus.bitrev_out    = 1'b0;
    bus.ntt_out_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".busy"},      bus.busy, 0);
    check({tag, ".done"},      bus.done, 0);
    check({tag, ".rd_en"},     bus.rd_en, 0);
    check({tag, ".rd_addr"},   bus.rd_addr, 0);
    check({tag, ".ntt_start"}, bus.ntt_start, 0);
    check({tag, ".ntt_intt"},  bus.ntt_intt, 0);
    check({tag, ".in_valid"},  bus.ntt_in_valid, 0);
    check({tag, ".wr_en"},     bus.wr_en, 0);
    check({tag, ".wr_addr"},   bus.wr_addr, 0);
    check({tag, ".poly_done"}, bus.poly_done, 0);
    check({tag, ".error"},     bus.error, 0);
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic do_run(input logic [2:0] np, input logic iv, input logic br,
                        input int vstart, input bit gapped, input int mid,
                        input bit extra, output int done_at);
    int npc, t, w_reg, c, err_from, ea;
    bit vld, wr_exp;
    logic [2:0] wi;
    npc = (np == 0) ? 1 : (np > 4) ? 4 : int'(np);
    t = npc * 8;
    w_reg = 0;
    done_at = 100000;
    err_from = 100000;
    for (c = 0; c <= done_at + 1 && c < 300; c++) begin
      bus.start      = (c == 0) || (c == mid);
      bus.num_poly   = (c == 0) ? np : 3'd1;
      bus.intt       = (c == 0) ? iv : ~iv;
      bus.bitrev_out = (c == 0) ? br : ~br;
      vld = (c >= vstart && w_reg < t && (!gapped || ((c - vstart) % 2 == 0)))
            || (extra && c == done_at);
      bus.ntt_out_valid = vld;
      wr_exp = vld && c >= SD && c < done_at;
      @(negedge clk);
      check("busy", bus.busy, c >= 1 && c < done_at);
      check("done", bus.done, c == done_at);
      check("rd_en", bus.rd_en, c >= SD && c < SD + t);
      if (c >= SD && c < SD + t) check("rd_addr", bus.rd_addr, c - SD);
      check("in_valid", bus.ntt_in_valid, c >= SD + RL && c < SD + RL + t);
      check("ntt_start", bus.ntt_start, c >= SD && c < done_at);
      check("wr_en", bus.wr_en, wr_exp);
      if (wr_exp) begin
        wi = 3'(w_reg % 8);
        ea = (w_reg / 8) * 8 + int'(br ? rev3(wi) : wi);
        check("wr_addr", bus.wr_addr, ea);
      end
      if (c >= 1) begin
        check("ntt_intt", bus.ntt_intt, iv);
        check("poly_done", bus.poly_done, w_reg / 8);
        check("error", bus.error, c > err_from);
      end
      if (wr_exp) begin
        w_reg++;
        if (w_reg == t) done_at = c + 1;
      end
      if (extra && c == done_at) err_from = c;
      @(posedge clk); #1;
    end
    idle_inputs();
    check("run_complete", c == done_at + 2, 1);
  endtask

  initial begin
    int d;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    do_run(3'd1, 1'b0, 1'b0, 20, 1'b0, -1, 1'b0, d);
    check("single_done_cycle", d, 28);

    do_run(3'd3, 1'b1, 1'b1, 10, 1'b0, -1, 1'b0, d);
    check("multi_done_cycle", d, 34);

    do_run(3'd0, 1'b0, 1'b0, 20, 1'b0, -1, 1'b0, d);
    check("clamp0_done_cycle", d, 28);

    do_run(3'd7, 1'b0, 1'b1, 12, 1'b0, 15, 1'b0, d);
    check("clamp7_done_cycle", d, 44);

    do_run(3'd1, 1'b0, 1'b0, 14, 1'b1, -1, 1'b0, d);
    check("gapped_done_cycle", d, 29);

    // Stray valid while idle: flagged, not written.
    @(negedge clk);
    check("idle_err_before", bus.error, 0);
    @(posedge clk); #1;
    bus.ntt_out_valid = 1'b1;
    @(negedge clk);
    check("idle_valid_wr_en", bus.wr_en, 0);
    @(posedge clk); #1;
    bus.ntt_out_valid = 1'b0;
    @(negedge clk);
    check("idle_valid_error", bus.error, 1);
    @(posedge clk); #1;

    // Run clears the earlier error, then a 9th valid sets it again.
    do_run(3'd1, 1'b0, 1'b0, 20, 1'b0, -1, 1'b1, d);

    // Abort mid-read with reset.
    for (int c = 0; c <= 10; c++) begin
      bus.start         = (c == 0);
      bus.num_poly      = 3'd2;
      bus.intt          = 1'b1;
      bus.bitrev_out    = 1'b1;
      bus.ntt_out_valid = (c >= 6 && c <= 9);
      if (c == 10) rst = 1'b1;
      @(negedge clk);
      if (c == 10) begin
        check("pre_rst_rd_addr", bus.rd_addr, 6);
        check("pre_rst_busy", bus.busy, 1);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    check_zero("mid_rst");
    @(posedge clk); #1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("post_rst_done", bus.done, 0);
      check("post_rst_busy", bus.busy, 0);
      @(posedge clk); #1;
    end

    do_run(3'd1, 1'b1, 1'b0, 20, 1'b0, -1, 1'b0, d);
    check("restart_done_cycle", d, 28);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
